// File: rtl/mag_pulse_emulator.sv
// ---------------------------------------------------------------------------
// mag_pulse_emulator
//
// Transmit side of the once-per-revolution magnet (MAG2) index interface.
// Produces a programmable periodic index pulse that looks to the LED block
// exactly like the real magnetic sensor output, so the display can be spun
// up on the bench without the motor.
//
// Ports
//   CLK_10M     in   1         system clock
//   nReset      in   1         synchronous reset, active-low
//   enable      in   1         run a continuous pulse train
//   singleShot  in   1         one-cycle request: emit one pulse when idle
//   periodIn    in   PERIOD_W  requested period in clocks
//   periodLoad  in   1         one-cycle strobe: capture periodIn
//   periodAck   out  1         one-cycle: period accepted into the shadow
//   periodErr   out  1         one-cycle: period rejected (below MIN_PERIOD)
//   mag         out  1         emulated index pulse, registered, active-high
//   busy        out  1         high while in the PULSE or GAP state
//   revCount    out  16        pulses emitted, wraps 0xFFFF -> 0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module mag_pulse_emulator #(
   parameter int CLK_FREQ       = 10_000_000,
   parameter int GLB_FPS        = 15,
   parameter int DEFAULT_PERIOD = CLK_FREQ / GLB_FPS,
   parameter int PULSE_CYCLES   = 100,
   parameter int MIN_PERIOD     = 1_000,
   parameter int PERIOD_W       = 24
) (
   input  logic                CLK_10M,
   input  logic                nReset,
   input  logic                enable,
   input  logic                singleShot,
   input  logic [PERIOD_W-1:0] periodIn,
   input  logic                periodLoad,
   output logic                periodAck,
   output logic                periodErr,
   output logic                mag,
   output logic                busy,
   output logic [15:0]         revCount
);

   localparam logic [PERIOD_W-1:0] DEF_PERIOD = PERIOD_W'(DEFAULT_PERIOD);
   localparam logic [PERIOD_W-1:0] PULSE_LEN  = PERIOD_W'(PULSE_CYCLES);
   localparam logic [PERIOD_W-1:0] MIN_P      = PERIOD_W'(MIN_PERIOD);
   localparam logic [PERIOD_W-1:0] CNT_ONE    = PERIOD_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t                state_q,   state_d;
   logic [PERIOD_W-1:0]   cnt_q,     cnt_d;
   logic                  mag_q,     mag_d;
   logic [15:0]           rev_q,     rev_d;
   logic [PERIOD_W-1:0]   active_q,  active_d;
   logic [PERIOD_W-1:0]   shadow_q,  shadow_d;
   logic                  oneshot_q, oneshot_d;
   logic                  ack_q,     ack_d;
   logic                  err_q,     err_d;

   logic                  start;
   logic                  load_ok;

   // ------------------------------------------------------------------------
   // Next-state / output logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mag_d     = 1'b0;
      rev_d     = rev_q;
      active_d  = active_q;
      oneshot_d = oneshot_q;
      start     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (enable || singleShot) begin
               start     = 1'b1;
               // A request with enable high is a continuous run, not a one-shot.
               oneshot_d = !enable;
            end
         end

         ST_PULSE: begin
            if (cnt_q == PULSE_LEN) begin
               // Pulse has had its full width; mag drops on this edge.
               mag_d = 1'b0;
               if (enable || oneshot_q) begin
                  state_d = ST_GAP;
                  cnt_d   = cnt_q + CNT_ONE;
               end else begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end
            end else begin
               mag_d = 1'b1;
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         ST_GAP: begin
            if (!enable && !oneshot_q) begin
               // Continuous run stopped mid-gap: nothing left to finish.
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == active_q) begin
               if (enable && !oneshot_q) begin
                  start = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Common pulse-start action for IDLE->PULSE and GAP->PULSE. The shadow
      // period is only adopted here, so a running period is never altered.
      if (start) begin
         state_d  = ST_PULSE;
         cnt_d    = CNT_ONE;
         mag_d    = 1'b1;
         rev_d    = rev_q + 16'd1;
         active_d = shadow_q;
      end
   end

   // ------------------------------------------------------------------------
   // Period load: validate and stage into the shadow register
   // ------------------------------------------------------------------------
   always_comb begin
      load_ok  = periodLoad && (periodIn >= MIN_P);
      shadow_d = shadow_q;
      ack_d    = 1'b0;
      err_d    = 1'b0;
      if (periodLoad) begin
         if (load_ok) begin
            shadow_d = periodIn;
            ack_d    = 1'b1;
         end else begin
            err_d    = 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK_10M) begin
      if (!nReset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         mag_q     <= 1'b0;
         rev_q     <= 16'd0;
         active_q  <= DEF_PERIOD;
         shadow_q  <= DEF_PERIOD;
         oneshot_q <= 1'b0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mag_q     <= mag_d;
         rev_q     <= rev_d;
         active_q  <= active_d;
         shadow_q  <= shadow_d;
         oneshot_q <= oneshot_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
      end
   end

   assign mag       = mag_q;
   assign busy      = (state_q != ST_IDLE);
   assign revCount  = rev_q;
   assign periodAck = ack_q;
   assign periodErr = err_q;

endmodule
